// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and frame-length helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  function automatic int frame_len(input int clk_div, input int word_len, input int parity, input int stop_bits);
    return (1 + word_len + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clk_div;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divide-by-p_CLK_DIV counter; i_clr holds it at zero, o_tick marks terminal count
module uart_baud_tick #(
  parameter int p_CLK_DIV = 104
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = $clog2(p_CLK_DIV);
  logic [CW-1:0] cnt_q;
  assign o_tick = cnt_q == CW'(p_CLK_DIV - 1);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= (i_clr || o_tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready word in, start + LSB-first data + optional parity + stop bits out on o_tx
module uart_tx
  import uart_pkg::*;
#(
  parameter int p_CLK_DIV   = 104,
  parameter int p_WORD_LEN  = 8,
  parameter int p_PARITY    = 0,
  parameter int p_STOP_BITS = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [p_WORD_LEN-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int IW = $clog2(p_WORD_LEN);
  localparam logic LAST_STOP = p_STOP_BITS == 2;
  localparam logic HAS_PAR = p_PARITY != PAR_NONE;
  if (p_CLK_DIV < 2) begin : g_chk_div
    $error("uart_tx: p_CLK_DIV must be >= 2");
  end
  if (p_STOP_BITS != 1 && p_STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx: p_STOP_BITS must be 1 or 2");
  end
  if (p_PARITY < 0 || p_PARITY > 2) begin : g_chk_par
    $error("uart_tx: p_PARITY must be 0, 1 or 2");
  end
  if (p_WORD_LEN < 5 || p_WORD_LEN > 9) begin : g_chk_len
    $error("uart_tx: p_WORD_LEN must be 5..9");
  end
  uart_state_e           state_q;
  logic [p_WORD_LEN-1:0] hold_q, shift_q;
  logic [IW-1:0]         bit_q;
  logic                  stop_q, par_q, ready_q, tx_q, busy_q, done_q;
  logic                  tick, load;
  uart_baud_tick #(.p_CLK_DIV(p_CLK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state_q == S_IDLE),
    .o_tick (tick)
  );
  // the shifter takes the held word from idle, or straight from the last stop cycle for gapless frames
  assign load = !ready_q && (state_q == S_IDLE || (state_q == S_STOP && tick && stop_q == LAST_STOP));
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      ready_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_valid && ready_q) begin
        hold_q  <= i_data;
        ready_q <= 1'b0;
      end
      case (state_q)
        S_START: if (tick) begin
          state_q <= S_DATA;
          tx_q    <= shift_q[0];
          bit_q   <= '0;
        end
        S_DATA: if (tick) begin
          if (bit_q == IW'(p_WORD_LEN - 1)) begin
            state_q <= HAS_PAR ? S_PARITY : S_STOP;
            tx_q    <= HAS_PAR ? par_q : 1'b1;
            stop_q  <= 1'b0;
          end else begin
            bit_q   <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
          end
        end
        S_PARITY: if (tick) begin
          state_q <= S_STOP;
          tx_q    <= 1'b1;
          stop_q  <= 1'b0;
        end
        S_STOP: if (tick) begin
          if (stop_q == LAST_STOP) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else stop_q <= 1'b1;
        end
        default: ;
      endcase
      if (load) begin
        shift_q <= hold_q;
        par_q   <= ^hold_q ^ (p_PARITY == PAR_ODD);
        ready_q <= 1'b1;
        state_q <= S_START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end
    end
  end
  assign o_ready = ready_q;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a frame-level reference model
module tb_uart_tx;
  localparam int D = 4;
  logic       clk, rst;
  logic [8:0] din [4];
  logic [3:0] vld, rdy, tx, busy, done;
  logic [255:0] obs_tx, obs_busy, obs_done, obs_rdy, exp_tx, exp_busy, exp_done;
  int n_checks, n_fail;

  uart_tx #(.p_CLK_DIV(D), .p_WORD_LEN(8), .p_PARITY(0), .p_STOP_BITS(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_data(din[0][7:0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
  uart_tx #(.p_CLK_DIV(D), .p_WORD_LEN(8), .p_PARITY(1), .p_STOP_BITS(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(din[1][7:0]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
  uart_tx #(.p_CLK_DIV(D), .p_WORD_LEN(8), .p_PARITY(2), .p_STOP_BITS(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(din[2][7:0]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
  uart_tx #(.p_CLK_DIV(D), .p_WORD_LEN(7), .p_PARITY(0), .p_STOP_BITS(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(din[3][6:0]), .i_valid(vld[3]),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wl(input int k); return k == 3 ? 7 : 8; endfunction
  function automatic int par(input int k); return k == 1 ? 1 : (k == 2 ? 2 : 0); endfunction
  function automatic int sb(input int k); return k == 3 ? 2 : 1; endfunction

  // index 0 = the cycle right after the accept edge; each frame bit spans D cycles, done follows each frame
  task automatic model(input int k, input int nw, input logic [8:0] w0, input logic [8:0] w1);
    int pos;
    logic q[$];
    logic [8:0] w;
    logic p;
    exp_tx = '1; exp_busy = '0; exp_done = '0; pos = 1;
    for (int f = 0; f < nw; f++) begin
      w = (f == 0) ? w0 : w1;
      q.delete();
      q.push_back(1'b0);
      p = 1'b0;
      for (int j = 0; j < wl(k); j++) begin
        q.push_back(w[j]);
        p ^= w[j];
      end
      if (par(k) != 0) q.push_back(par(k) == 2 ? !p : p);
      for (int s = 0; s < sb(k); s++) q.push_back(1'b1);
      foreach (q[i]) repeat (D) begin
        exp_tx[pos] = q[i];
        exp_busy[pos] = 1'b1;
        pos++;
      end
      exp_done[pos] = 1'b1;
    end
  endtask

  task automatic capture(input int k, input int n);
    obs_tx = '1; obs_busy = '0; obs_done = '0; obs_rdy = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_tx[i] = tx[k]; obs_busy[i] = busy[k]; obs_done[i] = done[k]; obs_rdy[i] = rdy[k];
    end
  endtask

  task automatic send1(input int k, input logic [8:0] w);
    din[k] = w; vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0; din[k] = ~w;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({tx[k], rdy[k], busy[k], done[k]} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d got={tx,rdy,busy,done}=%b exp=1100", k, {tx[k], rdy[k], busy[k], done[k]});
      end
    end
  endtask

  task automatic test_8n1();
    logic [8:0] w;
    @(negedge clk);
    model(0, 1, 9'h0A5, 9'h0);
    fork send1(0, 9'h0A5); capture(0, 44); join
    n_checks++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL 8n1_a5_tx got=%h exp=%h", obs_tx, exp_tx); end
    n_checks++; if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL 8n1_a5_busy got=%h exp=%h", obs_busy, exp_busy); end
    n_checks++; if (obs_done !== exp_done) begin n_fail++; $display("FAIL 8n1_a5_done got=%h exp=%h", obs_done, exp_done); end
    n_checks++; if (obs_rdy[1:0] !== 2'b10) begin n_fail++; $display("FAIL 8n1_ready got=%b exp=10", obs_rdy[1:0]); end
    for (int i = 0; i < 3; i++) begin
      w = 9'($urandom_range(0, 255));
      model(0, 1, w, 9'h0);
      fork send1(0, w); capture(0, 44); join
      n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done) begin n_fail++; $display("FAIL 8n1_rand w=%h got=%h exp=%h", w, obs_tx, exp_tx); end
    end
  endtask

  task automatic test_parity();
    @(negedge clk);
    model(1, 1, 9'h007, 9'h0);
    fork send1(1, 9'h007); capture(1, 48); join
    n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done) begin n_fail++; $display("FAIL even_07_tx got=%h exp=%h", obs_tx, exp_tx); end
    n_checks++; if (obs_tx[38] !== 1'b1) begin n_fail++; $display("FAIL even_07_parity got=%b exp=1", obs_tx[38]); end
    n_checks++; if ($countones(obs_busy) != 44) begin n_fail++; $display("FAIL even_frame_len got=%0d exp=44", $countones(obs_busy)); end
    model(2, 1, 9'h007, 9'h0);
    fork send1(2, 9'h007); capture(2, 48); join
    n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done) begin n_fail++; $display("FAIL odd_07_tx got=%h exp=%h", obs_tx, exp_tx); end
    n_checks++; if (obs_tx[38] !== 1'b0) begin n_fail++; $display("FAIL odd_07_parity got=%b exp=0", obs_tx[38]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    model(0, 2, 9'h055, 9'h0AA);
    fork
      begin
        din[0] = 9'h055; vld[0] = 1'b1;
        @(negedge clk); din[0] = 9'h0AA;
        @(negedge clk);
        @(negedge clk); vld[0] = 1'b0;
      end
      capture(0, 84);
    join
    n_checks++; if (obs_tx !== exp_tx) begin n_fail++; $display("FAIL b2b_tx got=%h exp=%h", obs_tx, exp_tx); end
    n_checks++; if (obs_done !== exp_done) begin n_fail++; $display("FAIL b2b_done got=%h exp=%h", obs_done, exp_done); end
    n_checks++; if ($countones(obs_busy) != 80 || obs_busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy got=%h exp=%h", obs_busy, exp_busy); end
    n_checks++; if (obs_rdy[2:0] !== 3'b010) begin n_fail++; $display("FAIL b2b_ready got=%b exp=010", obs_rdy[2:0]); end
  endtask

  task automatic test_hold_ignore();
    @(negedge clk);
    model(0, 2, 9'h055, 9'h012);
    fork
      begin
        din[0] = 9'h055; vld[0] = 1'b1;
        @(negedge clk); din[0] = 9'h012;
        @(negedge clk);
        @(negedge clk); vld[0] = 1'b0;
        repeat (7) @(negedge clk);
        din[0] = 9'h0FF; vld[0] = 1'b1;
        repeat (10) @(negedge clk);
        vld[0] = 1'b0;
      end
      capture(0, 84);
    join
    n_checks++; if (obs_rdy[19:9] !== 11'h0) begin n_fail++; $display("FAIL hold_ready got=%b exp=0", obs_rdy[19:9]); end
    n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done) begin n_fail++; $display("FAIL hold_ignore_tx got=%h exp=%h", obs_tx, exp_tx); end
  endtask

  task automatic test_stop2();
    logic [8:0] w;
    @(negedge clk);
    model(3, 1, 9'h07F, 9'h0);
    fork send1(3, 9'h07F); capture(3, 44); join
    n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done) begin n_fail++; $display("FAIL stop2_7f_tx got=%h exp=%h", obs_tx, exp_tx); end
    n_checks++; if ($countones(obs_busy) != 40) begin n_fail++; $display("FAIL stop2_frame_len got=%0d exp=40", $countones(obs_busy)); end
    n_checks++; if (obs_tx[40:29] !== 12'hFFF || obs_tx[28] !== 1'b1) begin n_fail++; $display("FAIL stop2_stop_period got=%b", obs_tx[40:28]); end
    w = 9'($urandom_range(0, 127));
    model(3, 1, w, 9'h0);
    fork send1(3, w); capture(3, 44); join
    n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done) begin n_fail++; $display("FAIL stop2_rand w=%h got=%h exp=%h", w, obs_tx, exp_tx); end
  endtask

  task automatic test_random();
    logic [8:0] w;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) begin
        w = 9'($urandom_range(0, (1 << wl(k)) - 1));
        @(negedge clk);
        model(k, 1, w, 9'h0);
        fork send1(k, w); capture(k, 50); join
        n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done || obs_busy !== exp_busy) begin n_fail++; $display("FAIL rand dut%0d w=%h got=%h exp=%h", k, w, obs_tx, exp_tx); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    int n_high;
    @(negedge clk);
    send1(0, 9'h0A5);
    repeat (18) @(negedge clk);
    n_checks++; if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_bit3_before_rst got tx=%b busy=%b exp tx=0 busy=1", tx[0], busy[0]); end
    rst = 1'b1;
    #1;
    n_checks++; if ({tx[0], rdy[0], busy[0], done[0]} !== 4'b1100) begin n_fail++; $display("FAIL mid_rst_immediate got=%b exp=1100", {tx[0], rdy[0], busy[0], done[0]}); end
    n_done = 0; n_high = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      n_done += int'(done[0]);
      n_high += int'(tx[0]);
    end
    n_checks++; if (n_done != 0 || n_high != 12) begin n_fail++; $display("FAIL mid_rst_abort got done=%0d tx_high=%0d exp done=0 tx_high=12", n_done, n_high); end
    model(0, 1, 9'h03C, 9'h0);
    fork send1(0, 9'h03C); capture(0, 44); join
    n_checks++; if (obs_tx !== exp_tx || obs_done !== exp_done) begin n_fail++; $display("FAIL mid_rst_after_3c got=%h exp=%h", obs_tx, exp_tx); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; vld = '0;
    for (int k = 0; k < 4; k++) din[k] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_8n1();
    test_parity();
    test_back_to_back();
    test_hold_ignore();
    test_stop2();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
